// File: rtl/tilexy_inj_arb.sv
// Injection arbiter and credit controller sharing the tile XY FIFO write port between REQN requesters.
// Build option TILEXY_ARB_PRIO_EN: requester 0 gets fixed priority with a starvation guard.
module tilexy_inj_arb #(
  parameter int REQN    = 3,
  parameter int CREDITS = 8,
  parameter int CW      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REQN-1:0]     req_valid,
  output logic [REQN-1:0]     req_ready,
  input  logic [REQN*37-1:0]  req_addr,
  input  logic [REQN*12-1:0]  req_size,
  input  logic [REQN*528-1:0] req_data,
  input  logic                wrt_stall,
  input  logic                credit_ret,
  input  logic                drain,
  output logic                out_en,
  output logic [527:0]        out_datum,
  output logic [36:0]         out_addr,
  output logic [11:0]         out_size,
  output logic [CW-1:0]       credits,
  output logic [1:0]          state,
  output logic                drained
);

  localparam int RW = $clog2(REQN);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [RW-1:0] RR_RST   = RW'(REQN - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } st_e;

  st_e           state_q, state_d;
  logic [CW-1:0] credits_q, credits_d;
  logic [RW-1:0] rr_q, rr_d;
  logic          out_en_q, out_en_d;
  logic [527:0]  out_datum_q, out_datum_d;
  logic [36:0]   out_addr_q, out_addr_d;
  logic [11:0]   out_size_q, out_size_d;
  logic          can_issue, gnt_found, accept;
  logic [RW-1:0] gnt_idx;

`ifdef TILEXY_ARB_PRIO_EN
  logic [3:0] starve_q, starve_d;
  logic       other_valid;

  // Rotating search restricted to requesters 1..REQN-1.
  function automatic logic [RW-1:0] hi_wrap(input int v);
    return RW'(1 + (v % (REQN - 1)));
  endfunction
`else
  function automatic logic [RW-1:0] rr_wrap(input int v);
    return RW'(v % REQN);
  endfunction
`endif

  // Handshake: a request moves when req_valid[g] & req_ready[g]; ready is computed from
  // the arbiter state and req_valid only, never from another requester's ready.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    can_issue = (state_q == ST_RUN) && (credits_q != '0) && !wrt_stall;
`ifdef TILEXY_ARB_PRIO_EN
    other_valid = |req_valid[REQN-1:1];
    if (req_valid[0] && !((starve_q >= 4'd8) && other_valid)) begin
      gnt_found = 1'b1;
    end else begin
      for (int i = 1; i < REQN; i++) begin
        if (!gnt_found && req_valid[hi_wrap(int'(rr_q) - 1 + i)]) begin
          gnt_found = 1'b1;
          gnt_idx   = hi_wrap(int'(rr_q) - 1 + i);
        end
      end
    end
`else
    for (int i = 1; i <= REQN; i++) begin
      if (!gnt_found && req_valid[rr_wrap(int'(rr_q) + i)]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_wrap(int'(rr_q) + i);
      end
    end
`endif
    accept    = can_issue && gnt_found;
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    out_en_d    = accept;
    out_datum_d = out_datum_q;
    out_addr_d  = out_addr_q;
    out_size_d  = out_size_q;
    rr_d        = rr_q;
    if (accept) begin
      out_datum_d = req_data[int'(gnt_idx)*528 +: 528];
      out_addr_d  = req_addr[int'(gnt_idx)*37 +: 37];
      out_size_d  = req_size[int'(gnt_idx)*12 +: 12];
`ifdef TILEXY_ARB_PRIO_EN
      if (gnt_idx != '0) rr_d = gnt_idx;
`else
      rr_d = gnt_idx;
`endif
    end

`ifdef TILEXY_ARB_PRIO_EN
    starve_d = starve_q;
    if (!other_valid) starve_d = '0;
    else if (accept) begin
      if (gnt_idx != '0) starve_d = '0;
      else if (starve_q != 4'hF) starve_d = starve_q + 4'd1;
    end
`endif

    // Simultaneous take and return cancel; returns beyond the pool size are dropped.
    credits_d = credits_q;
    if (accept && !credit_ret) credits_d = credits_q - CW'(1);
    else if (!accept && credit_ret && credits_q != CRED_MAX) credits_d = credits_q + CW'(1);

    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (drain) state_d = ST_DRAIN;
        else if (credits_d == '0 || wrt_stall) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (drain) state_d = ST_DRAIN;
        else if (!wrt_stall && credits_d != '0) state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (!drain && credits_q == CRED_MAX) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      credits_q   <= CRED_MAX;
      rr_q        <= RR_RST;
      out_en_q    <= 1'b0;
      out_datum_q <= '0;
      out_addr_q  <= '0;
      out_size_q  <= '0;
`ifdef TILEXY_ARB_PRIO_EN
      starve_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      credits_q   <= credits_d;
      rr_q        <= rr_d;
      out_en_q    <= out_en_d;
      out_datum_q <= out_datum_d;
      out_addr_q  <= out_addr_d;
      out_size_q  <= out_size_d;
`ifdef TILEXY_ARB_PRIO_EN
      starve_q    <= starve_d;
`endif
    end
  end

  assign out_en    = out_en_q;
  assign out_datum = out_datum_q;
  assign out_addr  = out_addr_q;
  assign out_size  = out_size_q;
  assign credits   = credits_q;
  assign state     = state_q;
  assign drained   = (state_q == ST_DRAIN) && (credits_q == CRED_MAX);

endmodule

// File: tb/tb_tilexy_inj_arb.sv
// Bench for tilexy_inj_arb: directed steps plus randomized traffic against a cycle reference model.
module tb_tilexy_inj_arb;
  localparam int REQN    = 3;
  localparam int CREDITS = 8;
  localparam int CW      = 4;

  // clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [REQN-1:0]     req_valid, req_ready;
  logic [REQN*37-1:0]  req_addr;
  logic [REQN*12-1:0]  req_size;
  logic [REQN*528-1:0] req_data;
  logic                wrt_stall, credit_ret, drain;
  logic                out_en, drained;
  logic [527:0]        out_datum;
  logic [36:0]         out_addr;
  logic [11:0]         out_size;
  logic [CW-1:0]       credits;
  logic [1:0]          state;

  logic [36:0]  r_addr [REQN];
  logic [11:0]  r_size [REQN];
  logic [527:0] r_data [REQN];

  for (genvar gi = 0; gi < REQN; gi++) begin : g_pack
    assign req_addr[gi*37 +: 37]   = r_addr[gi];
    assign req_size[gi*12 +: 12]   = r_size[gi];
    assign req_data[gi*528 +: 528] = r_data[gi];
  end

  tilexy_inj_arb #(.REQN(REQN), .CREDITS(CREDITS), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_data(req_data),
    .wrt_stall(wrt_stall), .credit_ret(credit_ret), .drain(drain),
    .out_en(out_en), .out_datum(out_datum), .out_addr(out_addr), .out_size(out_size),
    .credits(credits), .state(state), .drained(drained)
  );

  int n_tests, n_fail;
  int dut_g;

  // reference model
  int           m_cred, m_st, m_rr, m_zero_run, m_g;
  logic         m_oen;
  logic [36:0]  m_oaddr;
  logic [11:0]  m_osize;
  logic [527:0] m_odata;
  logic [36:0]  exp_q[$];

  task automatic chk(input string tag, input logic [527:0] obs, input logic [527:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cred = CREDITS; m_st = 0; m_rr = REQN - 1; m_zero_run = 0; m_g = -1;
    m_oen = 1'b0; m_oaddr = '0; m_osize = '0; m_odata = '0;
    exp_q.delete();
  endtask

  function automatic int winner(input logic [REQN-1:0] v);
`ifdef TILEXY_ARB_PRIO_EN
    bit others;
    others = (v >> 1) != 0;
    if (v[0] && !(m_zero_run >= 8 && others)) return 0;
    for (int k = 1; k < REQN; k++) begin
      int c;
      c = 1 + ((m_rr - 1 + k) % (REQN - 1));
      if (v[c]) return c;
    end
`else
    for (int k = 1; k <= REQN; k++) begin
      int c;
      c = (m_rr + k) % REQN;
      if (v[c]) return c;
    end
`endif
    return -1;
  endfunction

  task automatic new_payload(input int i);
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    r_addr[i] = t[36:0];
    r_size[i] = 12'($urandom());
    for (int k = 0; k < 17; k++) r_data[i][k*32 +: 32] = $urandom();
  endtask

  task automatic check_comb();
    logic [REQN-1:0] er;
    bit can;
    can = (m_st == 0) && (m_cred != 0) && !wrt_stall;
    m_g = can ? winner(req_valid) : -1;
    er = '0;
    if (m_g >= 0) er[m_g] = 1'b1;
    chk("req_ready", 528'(req_ready), 528'(er));
    dut_g = -1;
    for (int i = 0; i < REQN; i++) if (req_ready[i]) dut_g = i;
  endtask

  task automatic model_update();
    int nc, ns;
    bit acc, others;
    if (rst) begin
      model_reset();
      return;
    end
    acc = (m_g >= 0);
    others = (req_valid >> 1) != 0;
    m_oen = acc;
    if (acc) begin
      m_oaddr = r_addr[m_g]; m_osize = r_size[m_g]; m_odata = r_data[m_g];
      exp_q.push_back(r_addr[m_g]);
    end
`ifdef TILEXY_ARB_PRIO_EN
    if (acc && m_g != 0) m_rr = m_g;
    if (!others || (acc && m_g != 0)) m_zero_run = 0;
    else if (acc) m_zero_run++;
`else
    if (acc) m_rr = m_g;
`endif
    nc = m_cred;
    if (acc && !credit_ret) nc = m_cred - 1;
    else if (!acc && credit_ret && m_cred < CREDITS) nc = m_cred + 1;
    ns = m_st;
    if (m_st == 2) begin
      if (!drain && m_cred == CREDITS) ns = 0;
    end else if (drain) ns = 2;
    else if (m_st == 0 && (nc == 0 || wrt_stall)) ns = 1;
    else if (m_st == 1 && !wrt_stall && nc != 0) ns = 0;
    m_cred = nc;
    m_st = ns;
  endtask

  task automatic check_regs();
    chk("out_en", 528'(out_en), 528'(m_oen));
    if (m_oen && exp_q.size() > 0) chk("sb_addr", 528'(out_addr), 528'(exp_q.pop_front()));
    chk("out_addr", 528'(out_addr), 528'(m_oaddr));
    chk("out_size", 528'(out_size), 528'(m_osize));
    chk("out_datum", out_datum, m_odata);
    chk("credits", 528'(credits), 528'(m_cred));
    chk("state", 528'(state), 528'(m_st));
    chk("drained", 528'(drained), 528'((m_st == 2) && (m_cred == CREDITS)));
  endtask

  // driver: inputs change at posedge+1, comb outputs checked at negedge
  task automatic tick();
    @(negedge clk);
    check_comb();
    @(posedge clk);
    model_update();
    #1;
    check_regs();
  endtask

  initial begin
    n_tests = 0; n_fail = 0; dut_g = -1;
    rst = 1'b1; req_valid = '0; wrt_stall = 1'b0; credit_ret = 1'b0; drain = 1'b0;
    for (int i = 0; i < REQN; i++) new_payload(i);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tick();
    chk("rst_out_en", 528'(out_en), 528'(0));
    chk("rst_credits", 528'(credits), 528'(CREDITS));
    chk("rst_state", 528'(state), 528'(0));
    chk("rst_drained", 528'(drained), 528'(0));
    rst = 1'b0;

    // all valid, credit returned every cycle
    req_valid = '1; credit_ret = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
`ifndef TILEXY_ARB_PRIO_EN
      chk("rr_seq", 528'(dut_g), 528'(i % 3));
`endif
      chk("rr_out_en", 528'(out_en), 528'(1));
    end
    chk("rr_credits", 528'(credits), 528'(CREDITS));

    // credit exhaustion
    req_valid = 3'b010; credit_ret = 1'b0;
    for (int i = 0; i < CREDITS; i++) begin
      tick();
      chk("exh_gnt", 528'(dut_g), 528'(1));
    end
    chk("exh_credits", 528'(credits), 528'(0));
    chk("exh_state", 528'(state), 528'(1));
    tick();
    chk("exh_blocked", 528'(dut_g), 528'(-1));
    credit_ret = 1'b1;
    tick();
    chk("ret_credits", 528'(credits), 528'(1));
    credit_ret = 1'b0;
    tick();
    chk("ret_gnt", 528'(dut_g), 528'(1));
    chk("ret_out_en", 528'(out_en), 528'(1));
    chk("ret_hold", 528'(state), 528'(1));

    // refill, then stall with requester 2
    req_valid = '0; credit_ret = 1'b1;
    repeat (CREDITS) tick();
    chk("refill", 528'(credits), 528'(CREDITS));
    credit_ret = 1'b0; req_valid = 3'b100; wrt_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_gnt", 528'(dut_g), 528'(-1));
      chk("stall_out_en", 528'(out_en), 528'(0));
      chk("stall_credits", 528'(credits), 528'(CREDITS));
    end
    wrt_stall = 1'b0;
    tick();
    chk("unstall_gnt0", 528'(dut_g), 528'(-1));
    tick();
    chk("unstall_gnt1", 528'(dut_g), 528'(2));
    chk("unstall_credits", 528'(credits), 528'(CREDITS - 1));

    // drain from 5 credits
    repeat (2) tick();
    chk("pre_drain", 528'(credits), 528'(5));
    req_valid = '0; drain = 1'b1;
    tick();
    chk("drain_state", 528'(state), 528'(2));
    req_valid = '1;
    for (int p = 0; p < 3; p++) begin
      credit_ret = 1'b0;
      tick();
      chk("drain_nogrant", 528'(dut_g), 528'(-1));
      chk("drain_wait", 528'(drained), 528'(0));
      credit_ret = 1'b1;
      tick();
      chk("drain_done", 528'(drained), 528'(p == 2));
    end
    credit_ret = 1'b0; drain = 1'b0;
    tick();
    chk("undrain_state", 528'(state), 528'(0));
    tick();
    chk("undrain_gnt", 528'(dut_g), 528'(0));

    // simultaneous accept/return and saturation
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 3'b001;
    repeat (5) tick();
    chk("cred3", 528'(credits), 528'(3));
    credit_ret = 1'b1;
    tick();
    chk("both_gnt", 528'(dut_g), 528'(0));
    chk("both_credits", 528'(credits), 528'(3));
    req_valid = '0;
    repeat (6) tick();
    chk("sat_credits", 528'(credits), 528'(CREDITS));

    // requesters 0 and 1 contending
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 3'b011; credit_ret = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick();
`ifdef TILEXY_ARB_PRIO_EN
      chk("prio_seq", 528'(dut_g), 528'((i % 9 == 8) ? 1 : 0));
`else
      chk("alt_seq", 528'(dut_g), 528'(i % 2));
`endif
    end

    // reset mid-operation
    req_valid = '1; credit_ret = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_out_en", 528'(out_en), 528'(0));
    chk("midrst_credits", 528'(credits), 528'(CREDITS));
    rst = 1'b0;

    // randomized traffic; a request stays stable until accepted
    req_valid = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < REQN; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) req_valid[i] = 1'b1;
      wrt_stall  = ($urandom_range(0, 7) == 0);
      credit_ret = ($urandom_range(0, 2) == 0);
      drain      = ((cyc % 160) >= 110) && ((cyc % 160) < 140);
      tick();
      if (m_g >= 0) begin
        new_payload(m_g);
        req_valid[m_g] = 1'($urandom_range(0, 1));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
